// File: rtl/multiplier_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_adder.sv
// Behavioural W-bit adder used for the accumulate step; carry out is discarded.
module adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier: one multiplier bit per clock, product
// taken modulo 2^OUT_BITS and held with a finished flag.
module seq_multiplier
    import multiplier_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 16
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic [IN_BITS-1:0]  in_a,
    input  logic [IN_BITS-1:0]  in_b,
    input  logic                in_start,
    output logic                out_finished,
    output logic [OUT_BITS-1:0] out_prod
);

    localparam int CW = $clog2(IN_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(IN_BITS - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUT_BITS-1:0] a_q, a_d;
    logic [IN_BITS-1:0]  b_q, b_d;
    logic [OUT_BITS-1:0] acc_q, acc_d;

    logic [IN_BITS-1:0]  b_shift;
    logic [OUT_BITS-1:0] addend;
    logic [OUT_BITS-1:0] sum;

    // Shifting out of range simply yields zero, so the addend is
    // naturally truncated to OUT_BITS.
    assign b_shift = b_q >> cnt_q;
    assign addend  = b_shift[0] ? (a_q << cnt_q) : '0;

    adder #(.W(OUT_BITS)) u_adder (
        .a_i   (acc_q),
        .b_i   (addend),
        .sum_o (sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (in_start) begin
                    a_d     = OUT_BITS'(in_a);
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign out_prod     = acc_q;
    assign out_finished = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a 16-bit and a truncating 8-bit instance
// share stimulus; a scoreboard monitor checks product and latency.
module tb_seq_multiplier;

    typedef struct {
        logic [15:0] prod;
        int          start;
    } item_t;

    logic        in_clk;
    logic        in_rst;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_start;
    logic        fin16, fin8;
    logic [15:0] prod16;
    logic [7:0]  prod8;

    item_t q16[$];
    item_t q8[$];
    int    n_cmp;
    int    n_err;
    int    cyc;
    logic  req_zero;
    logic  req_fin0;

    seq_multiplier #(.IN_BITS(8), .OUT_BITS(16)) dut16 (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_start     (in_start),
        .out_finished (fin16),
        .out_prod     (prod16)
    );

    seq_multiplier #(.IN_BITS(8), .OUT_BITS(8)) dut8 (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_start     (in_start),
        .out_finished (fin8),
        .out_prod     (prod8)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    // Monitor: sole owner of the comparison counters.
    initial begin
        logic        prev16, prev8;
        logic [15:0] last16, last8;
        item_t       it;
        n_cmp  = 0;
        n_err  = 0;
        prev16 = 1'b0;
        prev8  = 1'b0;
        last16 = '0;
        last8  = '0;
        forever begin
            @(negedge in_clk);
            if (req_zero) begin
                n_cmp++;
                if (fin16 !== 1'b0 || prod16 !== 16'd0 || fin8 !== 1'b0 || prod8 !== 8'd0) begin
                    n_err++;
                    $display("FAIL reset_zero: fin16=%b prod16=%0d fin8=%b prod8=%0d, required all 0",
                             fin16, prod16, fin8, prod8);
                end
            end
            if (req_fin0) begin
                n_cmp++;
                if (fin16 !== 1'b0 || fin8 !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_drop: fin16=%b fin8=%b, required 0", fin16, fin8);
                end
            end
            // 16-bit instance
            if (fin16 === 1'b1 && !prev16) begin
                n_cmp++;
                if (q16.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected16: prod=%0d with nothing expected", prod16);
                end else begin
                    it = q16.pop_front();
                    last16 = it.prod;
                    if (prod16 !== it.prod || cyc - it.start != 8) begin
                        n_err++;
                        $display("FAIL prod16: got %0d after %0d cycles, required %0d after 8",
                                 prod16, cyc - it.start, it.prod);
                    end
                end
            end else if (fin16 === 1'b1 && prev16) begin
                n_cmp++;
                if (prod16 !== last16) begin
                    n_err++;
                    $display("FAIL hold16: got %0d, required %0d", prod16, last16);
                end
            end
            if (q16.size() != 0 && cyc - q16[0].start > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout16: no result, required %0d", q16[0].prod);
                void'(q16.pop_front());
            end
            prev16 = fin16;
            // 8-bit truncating instance
            if (fin8 === 1'b1 && !prev8) begin
                n_cmp++;
                if (q8.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected8: prod=%0d with nothing expected", prod8);
                end else begin
                    it = q8.pop_front();
                    last8 = it.prod;
                    if ({8'd0, prod8} !== it.prod || cyc - it.start != 8) begin
                        n_err++;
                        $display("FAIL prod8: got %0d after %0d cycles, required %0d after 8",
                                 prod8, cyc - it.start, it.prod);
                    end
                end
            end else if (fin8 === 1'b1 && prev8) begin
                n_cmp++;
                if ({8'd0, prod8} !== last8) begin
                    n_err++;
                    $display("FAIL hold8: got %0d, required %0d", prod8, last8);
                end
            end
            if (q8.size() != 0 && cyc - q8[0].start > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout8: no result, required %0d", q8[0].prod);
                void'(q8.pop_front());
            end
            prev8 = fin8;
        end
    end

    task automatic push(input logic [15:0] e16, input logic [15:0] e8, input int s);
        item_t it;
        it.start = s;
        it.prod  = e16;
        q16.push_back(it);
        it.prod  = e8;
        q8.push_back(it);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] e16, input logic [15:0] e8);
        @(negedge in_clk);
        in_a     = a;
        in_b     = b;
        in_start = 1'b1;
        push(e16, e8, cyc + 1);
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        req_fin0 = 1'b1;
        @(negedge in_clk);
        #1;
        req_fin0 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && (q16.size() != 0 || q8.size() != 0); i++)
            @(posedge in_clk);
    endtask

    task automatic check_zero();
        @(posedge in_clk);
        #1;
        req_zero = 1'b1;
        @(negedge in_clk);
        #1;
        req_zero = 1'b0;
    endtask

    initial begin
        in_rst   = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_start = 1'b0;
        req_zero = 1'b0;
        req_fin0 = 1'b0;
        repeat (2) @(posedge in_clk);
        check_zero();
        @(negedge in_clk);
        in_rst = 1'b1;

        start_op(8'd123, 8'd234, 16'd28782, 16'd110);
        wait_idle();
        repeat (3) @(posedge in_clk);
        start_op(8'd255, 8'd255, 16'd65025, 16'd1);
        wait_idle();
        start_op(8'd0,   8'd200, 16'd0,     16'd0);
        wait_idle();
        start_op(8'd1,   8'd1,   16'd1,     16'd1);
        wait_idle();

        // Operand change and a stray start pulse while running
        start_op(8'd25, 8'd11, 16'd275, 16'd19);
        repeat (2) @(negedge in_clk);
        in_a = 8'd7;
        in_b = 8'd9;
        @(negedge in_clk);
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        wait_idle();

        // Restart from DONE
        repeat (2) @(posedge in_clk);
        start_op(8'd10, 8'd20, 16'd200, 16'd200);
        wait_idle();
        start_op(8'd16, 8'd17, 16'd272, 16'd16);
        wait_idle();

        // Start held high: three back-to-back products, one every 9 cycles
        @(negedge in_clk);
        in_a     = 8'd3;
        in_b     = 8'd5;
        in_start = 1'b1;
        push(16'd15, 16'd15, cyc + 1);
        push(16'd15, 16'd15, cyc + 10);
        push(16'd15, 16'd15, cyc + 19);
        repeat (19) @(posedge in_clk);
        #1;
        in_start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-run, then idle until a new start
        @(negedge in_clk);
        in_a     = 8'd255;
        in_b     = 8'd255;
        in_start = 1'b1;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        repeat (3) @(posedge in_clk);
        #2;
        in_rst   = 1'b0;
        #1;
        req_zero = 1'b1;
        @(negedge in_clk);
        #1;
        req_zero = 1'b0;
        @(negedge in_clk);
        in_rst = 1'b1;
        repeat (12) @(posedge in_clk);
        check_zero();
        start_op(8'd12, 8'd12, 16'd144, 16'd144);
        wait_idle();

        repeat (3) @(posedge in_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
